// File: rtl/lut_dds_multich.sv
// lut_dds_multich: multi-channel DDS sharing one quarter-wave LUT with mirror reconstruction.
// Optional amplitude stage is built when LUT_DDS_AMP_SCALE_EN is defined.
module lut_dds_multich #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned BIT_WIDTH   = 12,
    parameter int unsigned LUT_DEPTH   = 64,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned AMP_WIDTH   = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ADDR_W     = $clog2(LUT_DEPTH)
) (
    input  logic                        CLK_SYS,
    input  logic                        nRST,
    input  logic                        EN,
    input  logic                        SAMPLE_TICK,
    input  logic                        PHASE_CLR,
    input  logic                        LUT_WE,
    input  logic [ADDR_W-1:0]           LUT_ADDR,
    input  logic [BIT_WIDTH-2:0]        LUT_DATA,
    input  logic                        CFG_WE,
    input  logic [CH_W-1:0]             CFG_CH,
    input  logic [1:0]                  CFG_SEL,
    input  logic [PHASE_WIDTH-1:0]      CFG_DATA,
    output logic                        OUT_VALID,
    output logic [CH_W-1:0]             OUT_CH,
    output logic signed [BIT_WIDTH-1:0] OUT_DATA,
    output logic                        FRAME_DONE,
    output logic                        BUSY,
    output logic                        OVERRUN
);

    localparam int unsigned MAG_W   = BIT_WIDTH - 1;
    localparam int unsigned TOP_W   = 2 + ADDR_W;
    localparam int unsigned FRAC_W  = PHASE_WIDTH - TOP_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    // Sequencer
    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   issue_c;

    // Per-channel configuration and phase state
    logic [PHASE_WIDTH-1:0] acc_q [NUM_CH];
    logic [PHASE_WIDTH-1:0] acc_d [NUM_CH];
    logic [PHASE_WIDTH-1:0] ftw_q [NUM_CH];
    logic [PHASE_WIDTH-1:0] ftw_d [NUM_CH];
    logic [PHASE_WIDTH-1:0] off_q [NUM_CH];
    logic [PHASE_WIDTH-1:0] off_d [NUM_CH];

    // Quarter-wave magnitude table, not reset
    logic [MAG_W-1:0]       lut_mem [LUT_DEPTH];

    // Pipeline
    logic [PHASE_WIDTH-1:0] phase_c;
    logic [TOP_W-1:0]       phase_top_c;
    logic [1:0]             quad_c;
    logic [ADDR_W-1:0]      addr_c;

    logic                   s1_vld_q, s1_vld_d;
    logic [CH_W-1:0]        s1_ch_q, s1_ch_d;
    logic [ADDR_W-1:0]      s1_addr_q, s1_addr_d;
    logic                   s1_neg_q, s1_neg_d;

    logic                   s2_vld_q, s2_vld_d;
    logic [CH_W-1:0]        s2_ch_q, s2_ch_d;
    logic [MAG_W-1:0]       s2_m_q, s2_m_d;
    logic                   s2_neg_q, s2_neg_d;

    logic signed [BIT_WIDTH-1:0] mirror_c;
    logic [CH_W-1:0]             src_ch_c;
    logic signed [BIT_WIDTH-1:0] src_data_c;

    logic                        out_valid_q, out_valid_d;
    logic [CH_W-1:0]             out_ch_q, out_ch_d;
    logic signed [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        frame_done_q, frame_done_d;

`ifdef LUT_DDS_AMP_SCALE_EN
    localparam int unsigned PROD_W = BIT_WIDTH + AMP_WIDTH + 1;
    localparam logic [AMP_WIDTH-1:0] AMP_UNITY = AMP_WIDTH'(1 << (AMP_WIDTH - 1));
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [AMP_WIDTH-1:0]        amp_q [NUM_CH];
    logic [AMP_WIDTH-1:0]        amp_d [NUM_CH];
    logic [AMP_WIDTH-1:0]        s1_amp_q, s1_amp_d;
    logic [AMP_WIDTH-1:0]        s2_amp_q, s2_amp_d;
    logic                        s3_vld_q, s3_vld_d;
    logic [CH_W-1:0]             s3_ch_q, s3_ch_d;
    logic signed [BIT_WIDTH-1:0] s3_data_q, s3_data_d;
    logic [AMP_WIDTH-1:0]        s3_amp_q, s3_amp_d;
    logic signed [PROD_W-1:0]    prod_c;
    logic signed [PROD_W-1:0]    scaled_c;
    logic signed [BIT_WIDTH-1:0] sat_c;
`endif

    // Frame sequencer: a tick on the last issue cycle chains the next frame
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        issue_c   = 1'b0;
        overrun_d = 1'b0;
        if (!EN) begin
            state_d = ST_IDLE;
            ch_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (SAMPLE_TICK) begin
                        state_d = ST_ISSUE;
                        ch_d    = '0;
                    end
                end
                ST_ISSUE: begin
                    issue_c = 1'b1;
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        if (!SAMPLE_TICK) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ch_d      = ch_q + CH_W'(1);
                        overrun_d = SAMPLE_TICK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_ISSUE);
    end

    // Channel registers: clear beats preload beats accumulate
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c] = acc_q[c];
            ftw_d[c] = ftw_q[c];
            off_d[c] = off_q[c];
            if (issue_c && (ch_q == CH_W'(c))) begin
                acc_d[c] = acc_q[c] + ftw_q[c];
            end
            if (CFG_WE && (CFG_CH == CH_W'(c))) begin
                case (CFG_SEL)
                    2'd0:    ftw_d[c] = CFG_DATA;
                    2'd1:    off_d[c] = CFG_DATA;
                    2'd3:    acc_d[c] = CFG_DATA;
                    default: ;
                endcase
            end
            if (PHASE_CLR) begin
                acc_d[c] = '0;
            end
        end
    end

`ifdef LUT_DDS_AMP_SCALE_EN
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            amp_d[c] = amp_q[c];
            if (CFG_WE && (CFG_SEL == 2'd2) && (CFG_CH == CH_W'(c))) begin
                amp_d[c] = CFG_DATA[AMP_WIDTH-1:0];
            end
        end
    end
`endif

    always_ff @(posedge CLK_SYS) begin
        if (LUT_WE) begin
            lut_mem[LUT_ADDR] <= LUT_DATA;
        end
    end

    // Address, LUT read and mirror stages
    always_comb begin
        phase_c     = acc_q[ch_q] + off_q[ch_q];
        phase_top_c = TOP_W'(phase_c >> FRAC_W);
        quad_c      = phase_top_c[TOP_W-1 -: 2];
        addr_c      = phase_top_c[ADDR_W-1:0];

        s1_vld_d  = issue_c;
        s1_ch_d   = ch_q;
        s1_addr_d = quad_c[0] ? ~addr_c : addr_c;
        s1_neg_d  = quad_c[1];

        s2_vld_d  = EN && s1_vld_q;
        s2_ch_d   = s1_ch_q;
        s2_m_d    = lut_mem[s1_addr_q];
        s2_neg_d  = s1_neg_q;

        mirror_c  = s2_neg_q ? {1'b1, ~s2_m_q} : {1'b0, s2_m_q};
    end

    // Output stage: amplitude scaling with saturation when present
    always_comb begin
`ifdef LUT_DDS_AMP_SCALE_EN
        s1_amp_d  = amp_q[ch_q];
        s2_amp_d  = s1_amp_q;
        s3_vld_d  = EN && s2_vld_q;
        s3_ch_d   = s2_ch_q;
        s3_data_d = mirror_c;
        s3_amp_d  = s2_amp_q;

        prod_c   = PROD_W'(s3_data_q) * PROD_W'($signed({1'b0, s3_amp_q}));
        scaled_c = prod_c >>> (AMP_WIDTH - 1);
        if (scaled_c > SAT_MAX) begin
            sat_c = BIT_WIDTH'(SAT_MAX);
        end else if (scaled_c < SAT_MIN) begin
            sat_c = BIT_WIDTH'(SAT_MIN);
        end else begin
            sat_c = BIT_WIDTH'(scaled_c);
        end

        out_valid_d = EN && s3_vld_q;
        src_ch_c    = s3_ch_q;
        src_data_c  = sat_c;
`else
        out_valid_d = EN && s2_vld_q;
        src_ch_c    = s2_ch_q;
        src_data_c  = mirror_c;
`endif
        out_ch_d     = out_valid_d ? src_ch_c : out_ch_q;
        out_data_d   = out_valid_d ? src_data_c : out_data_q;
        frame_done_d = out_valid_d && (src_ch_c == LAST_CH);
    end

    always_ff @(posedge CLK_SYS) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                ftw_q[c] <= '0;
                off_q[c] <= '0;
            end
            s1_vld_q     <= 1'b0;
            s1_ch_q      <= '0;
            s1_addr_q    <= '0;
            s1_neg_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_ch_q      <= '0;
            s2_m_q       <= '0;
            s2_neg_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                ftw_q[c] <= ftw_d[c];
                off_q[c] <= off_d[c];
            end
            s1_vld_q     <= s1_vld_d;
            s1_ch_q      <= s1_ch_d;
            s1_addr_q    <= s1_addr_d;
            s1_neg_q     <= s1_neg_d;
            s2_vld_q     <= s2_vld_d;
            s2_ch_q      <= s2_ch_d;
            s2_m_q       <= s2_m_d;
            s2_neg_q     <= s2_neg_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LUT_DDS_AMP_SCALE_EN
    always_ff @(posedge CLK_SYS) begin
        if (!nRST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                amp_q[c] <= AMP_UNITY;
            end
            s1_amp_q  <= '0;
            s2_amp_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_ch_q   <= '0;
            s3_data_q <= '0;
            s3_amp_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                amp_q[c] <= amp_d[c];
            end
            s1_amp_q  <= s1_amp_d;
            s2_amp_q  <= s2_amp_d;
            s3_vld_q  <= s3_vld_d;
            s3_ch_q   <= s3_ch_d;
            s3_data_q <= s3_data_d;
            s3_amp_q  <= s3_amp_d;
        end
    end
`endif

    assign OUT_VALID  = out_valid_q;
    assign OUT_CH     = out_ch_q;
    assign OUT_DATA   = out_data_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = busy_q;
    assign OVERRUN    = overrun_q;

endmodule
